// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared definitions for the register command controller: frame opcodes,
// FSM state encoding and a helper that identifies operand-wait states.
package reg_cmd_ctrl_pkg;

  localparam logic [7:0] OP_WRITE = 8'hAA;
  localparam logic [7:0] OP_READ  = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  // States in which the controller is waiting for the next frame byte.
  function automatic logic is_operand_wait(state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Register command controller: decodes AA/BB command frames from a byte
// stream into register-file writes and reads, and pushes read data to TX.
// Optional build macro: REG_CMD_TIMEOUT_EN enables the inter-byte watchdog
// that abandons incomplete frames after TIMEOUT idle cycles.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a command byte (AA write, BB read)
// WR_ADDR | write frame: waiting for the address byte
// WR_DATA | write frame: waiting for the data byte
// RD_ADDR | read frame: waiting for the address byte
// RD_WAIT | read strobe issued, waiting for RdData_VLD
// TX_SEND | holding read data until the TX buffer has room
module reg_cmd_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             TX_FULL,
  output logic [ADDR-1:0]  Address,
  output logic             WrEn,
  output logic             RdEn,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             Busy,
  output logic             Timeout_Err
);
  import reg_cmd_ctrl_pkg::*;

  state_t           state, state_nxt;
  logic [ADDR-1:0]  addr_nxt;
  logic [WIDTH-1:0] wr_data_nxt, tx_data_nxt;
  logic             wr_en_nxt, rd_en_nxt, tx_vld_nxt, to_err_nxt;
  logic             timeout_hit;

`ifdef REG_CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] idle_cnt;

  // Down-counter of idle cycles; reloaded on every byte and outside operand waits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idle_cnt <= CNT_LOAD;
    end else if (!is_operand_wait(state) || RX_D_VLD) begin
      idle_cnt <= CNT_LOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - CW'(1);
    end
  end

  assign timeout_hit = is_operand_wait(state) && !RX_D_VLD && (idle_cnt == '0);
`else
  // Watchdog compiled out: the frame waits forever and TIMEOUT has no effect.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // State register and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      Address     <= '0;
      WrData      <= '0;
      TX_P_DATA   <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      TX_D_VLD    <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_nxt;
      Address     <= addr_nxt;
      WrData      <= wr_data_nxt;
      TX_P_DATA   <= tx_data_nxt;
      WrEn        <= wr_en_nxt;
      RdEn        <= rd_en_nxt;
      TX_D_VLD    <= tx_vld_nxt;
      Timeout_Err <= to_err_nxt;
    end
  end

  // Next-state and next-output decode for the frame parser.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = Address;
    wr_data_nxt = WrData;
    tx_data_nxt = TX_P_DATA;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    tx_vld_nxt  = 1'b0;
    to_err_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(OP_WRITE)) begin
            state_nxt = WR_ADDR;
          end else if (RX_P_DATA == WIDTH'(OP_READ)) begin
            state_nxt = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nxt  = RX_P_DATA[ADDR-1:0];
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_nxt = RX_P_DATA;
          wr_en_nxt   = 1'b1;
          state_nxt   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_nxt  = RX_P_DATA[ADDR-1:0];
          rd_en_nxt = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RdData_VLD) begin
          tx_data_nxt = RdData;
          state_nxt   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!TX_FULL) begin
          tx_vld_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A stalled frame is abandoned; timeout_hit implies no byte this cycle.
    if (timeout_hit) begin
      state_nxt  = IDLE;
      to_err_nxt = 1'b1;
    end
  end

  assign Busy = (state != IDLE);

endmodule
